// File: rtl/sigdelay_pkg.sv
// Shared defaults and helpers for the multi-channel sample delay line.
package sigdelay_pkg;

  localparam int SD_D_WIDTH       = 8;
  localparam int SD_A_WIDTH       = 9;
  localparam int SD_NUM_CH        = 2;
  localparam int SD_DEFAULT_DELAY = 64;
  localparam int SD_FB_SHIFT      = 1;

  // A single channel still needs a 1-bit channel field on the ports.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/sigdelay_if.sv
// Sample intake, delay configuration and delayed-sample output bundle.
interface sigdelay_if #(
  parameter int D_WIDTH = sigdelay_pkg::SD_D_WIDTH,
  parameter int A_WIDTH = sigdelay_pkg::SD_A_WIDTH,
  parameter int NUM_CH  = sigdelay_pkg::SD_NUM_CH
) ();
  import sigdelay_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [CH_W-1:0]    in_ch;
  logic [D_WIDTH-1:0] din;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [A_WIDTH-1:0] cfg_delay;
  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [D_WIDTH-1:0] dout;

  modport master (
    output en, in_valid, in_ch, din, cfg_we, cfg_ch, cfg_delay,
    input  in_ready, out_valid, out_ch, dout
  );

  modport slave (
    input  en, in_valid, in_ch, din, cfg_we, cfg_ch, cfg_delay,
    output in_ready, out_valid, out_ch, dout
  );

endinterface

// File: rtl/sigdelay_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No read-during-write guarantee; callers resolve same-address collisions.
module sigdelay_ram #(
  parameter int D_WIDTH = sigdelay_pkg::SD_D_WIDTH,
  parameter int ADDR_W  = sigdelay_pkg::SD_A_WIDTH + 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sigdelay_multi.sv
// Multi-channel programmable sample delay sharing one RAM, 1-cycle latency.
// Optional echo feedback into the stored sample when SIGDELAY_ECHO_EN is defined.
module sigdelay_multi #(
  parameter int D_WIDTH       = sigdelay_pkg::SD_D_WIDTH,
  parameter int A_WIDTH       = sigdelay_pkg::SD_A_WIDTH,
  parameter int NUM_CH        = sigdelay_pkg::SD_NUM_CH,
  parameter int DEFAULT_DELAY = sigdelay_pkg::SD_DEFAULT_DELAY,
  parameter int FB_SHIFT      = sigdelay_pkg::SD_FB_SHIFT
) (
  input  logic      clk,
  input  logic      rst,
  sigdelay_if.slave io
);
  import sigdelay_pkg::*;

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int RAM_AW = $clog2(NUM_CH) + A_WIDTH;

  logic [A_WIDTH-1:0] wptr  [NUM_CH];
  logic [A_WIDTH-1:0] fill  [NUM_CH];
  logic [A_WIDTH-1:0] delay [NUM_CH];

  logic               accept;
  logic [A_WIDTH-1:0] cur_wptr;
  logic [A_WIDTH-1:0] cur_fill;
  logic [A_WIDTH-1:0] cur_delay;
  logic [RAM_AW-1:0]  rd_addr;
  logic [RAM_AW-1:0]  wr_addr_now;

  logic               out_valid_r;
  logic [CH_W-1:0]    out_ch_r;
  logic [D_WIDTH-1:0] din_r;
  logic               zero_r;
  logic               byp_r;
  logic [D_WIDTH-1:0] ram_q;
  logic [D_WIDTH-1:0] dout_c;

  logic               ram_we;
  logic [RAM_AW-1:0]  ram_waddr;
  logic [D_WIDTH-1:0] ram_wdata;

  assign io.in_ready = io.en & rst;
  assign accept      = io.in_valid & io.in_ready;

  assign cur_wptr    = wptr[io.in_ch];
  assign cur_fill    = fill[io.in_ch];
  assign cur_delay   = delay[io.in_ch];
  assign rd_addr     = RAM_AW'({io.in_ch, A_WIDTH'(cur_wptr - cur_delay)});
  assign wr_addr_now = RAM_AW'({io.in_ch, cur_wptr});

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i]  <= '0;
        fill[i]  <= '0;
        delay[i] <= A_WIDTH'(DEFAULT_DELAY);
      end
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      din_r       <= '0;
      zero_r      <= 1'b1;
      byp_r       <= 1'b0;
    end else begin
      out_valid_r <= accept;
      if (accept) begin
        wptr[io.in_ch] <= cur_wptr + 1'b1;
        if (cur_fill != '1) fill[io.in_ch] <= cur_fill + 1'b1;
        out_ch_r <= io.in_ch;
        din_r    <= io.din;
        // Not enough history yet: the RAM word is stale, so emit silence.
        zero_r   <= (cur_delay != '0) && (cur_fill < cur_delay);
        byp_r    <= (cur_delay == '0);
      end
      // Applied after this edge's read, so a coincident sample sees the old delay.
      if (io.cfg_we) delay[io.cfg_ch] <= io.cfg_delay;
    end
  end

`ifdef SIGDELAY_ECHO_EN
  // The stored word depends on the delayed read, so the write trails the accept
  // by one cycle; a read of that pending address is forwarded from here.
  logic               fwd_r;
  logic [D_WIDTH-1:0] fwd_dat;
  logic [RAM_AW-1:0]  wr_addr_r;
  logic [D_WIDTH-1:0] wr_dat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_r     <= 1'b0;
      fwd_dat   <= '0;
      wr_addr_r <= '0;
    end else if (accept) begin
      fwd_r     <= out_valid_r && (rd_addr == wr_addr_r);
      fwd_dat   <= wr_dat;
      wr_addr_r <= wr_addr_now;
    end
  end

  always_comb begin
    dout_c = ram_q;
    if (zero_r)     dout_c = '0;
    else if (byp_r) dout_c = din_r;
    else if (fwd_r) dout_c = fwd_dat;
  end

  always_comb begin
    wr_dat = din_r;
    if (!byp_r) wr_dat = D_WIDTH'(sat_add(32'(din_r), 32'(dout_c >> FB_SHIFT), D_WIDTH));
  end

  always_comb begin
    ram_we    = out_valid_r & rst;
    ram_waddr = wr_addr_r;
    ram_wdata = wr_dat;
  end
`else
  always_comb begin
    dout_c = ram_q;
    if (zero_r)     dout_c = '0;
    else if (byp_r) dout_c = din_r;
  end

  always_comb begin
    ram_we    = accept;
    ram_waddr = wr_addr_now;
    ram_wdata = io.din;
  end
`endif

  sigdelay_ram #(
    .D_WIDTH (D_WIDTH),
    .ADDR_W  (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign io.out_valid = out_valid_r;
  assign io.out_ch    = out_ch_r;
  assign io.dout      = dout_c;

endmodule

// File: tb/tb_sigdelay_multi.sv
// Directed and random stimulus for sigdelay_multi against a sample-history model.
module tb_sigdelay_multi;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int NCH   = 2;
  localparam int DDLY  = 64;
  localparam int FBS   = 1;
  localparam int DEPTH = 1 << AW;
  localparam int HLEN  = 2048;

  logic clk;
  logic rst;

  sigdelay_if #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_CH(NCH)) bus ();

  sigdelay_multi #(
    .D_WIDTH       (DW),
    .A_WIDTH       (AW),
    .NUM_CH        (NCH),
    .DEFAULT_DELAY (DDLY),
    .FB_SHIFT      (FBS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: every value ever stored per channel, in acceptance order.
  logic [DW-1:0] hist [NCH][HLEN];
  int            cnt    [NCH];
  int            mdelay [NCH];
  logic [DW-1:0] hold_dout;
  int            hold_ch;
  int            vectors;
  int            miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      cnt[c]    = 0;
      mdelay[c] = DDLY;
    end
    hold_dout = '0;
    hold_ch   = 0;
  endtask

  task automatic model_accept(input int ch, input logic [DW-1:0] d, output logic [DW-1:0] o);
    int n;
    int dl;
    int fl;
    int sum;
    logic [DW-1:0] st;
    n  = cnt[ch];
    dl = mdelay[ch];
    fl = (n > DEPTH - 1) ? DEPTH - 1 : n;
    if (dl == 0)      o = d;
    else if (fl < dl) o = '0;
    else              o = hist[ch][(n - dl) % HLEN];
    st = d;
`ifdef SIGDELAY_ECHO_EN
    if (dl != 0) begin
      sum = int'(d) + (int'(o) >> FBS);
      st  = (sum > (1 << DW) - 1) ? DW'((1 << DW) - 1) : DW'(sum);
    end
`else
    sum = 0;
`endif
    hist[ch][n % HLEN] = st;
    cnt[ch] = n + 1;
  endtask

  task automatic cycle(input bit vld, input int ch, input int d,
                       input bit cw, input int cch, input int cd);
    bit acc;
    logic [DW-1:0] exp;
    @(negedge clk);
    bus.in_valid  = vld;
    bus.in_ch     = 1'(ch);
    bus.din       = DW'(d);
    bus.cfg_we    = cw;
    bus.cfg_ch    = 1'(cch);
    bus.cfg_delay = AW'(cd);
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(bus.en & rst));
    acc = vld && bus.en && rst;
    exp = '0;
    if (acc) model_accept(ch, DW'(d), exp);
    if (cw && rst) mdelay[cch] = cd;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(acc));
      if (acc) begin
        hold_dout = exp;
        hold_ch   = ch;
      end
      chk("dout", 32'(bus.dout), 32'(hold_dout));
      chk("out_ch", 32'(bus.out_ch), 32'(hold_ch));
    end
  endtask

  initial begin
    int dly;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.en      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ch   = '0;
    bus.din     = '0;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_delay = '0;
    model_reset();

    // Reset, including an offered sample that must be refused.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 33, 0, 0, 0);
    rst = 1'b1;

    // Ramp on channel 0 with delay 4: four zeros, then 1,2,3,...
    cycle(0, 0, 0, 1, 0, 4);
    for (int i = 1; i <= 8; i++) cycle(1, 0, i, 0, 0, 0);

    // Delay 0 passes the same sample straight through.
    cycle(0, 0, 0, 1, 1, 0);
    cycle(1, 1, 8'hA5, 0, 0, 0);
    chk("bypass_a5", 32'(bus.dout), 32'h00A5);
    chk("bypass_ch", 32'(bus.out_ch), 32'd1);

    // Interleaved channels, delays 2 and 3.
    cycle(0, 0, 0, 1, 0, 2);
    cycle(0, 0, 0, 1, 1, 3);
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 10 * i, 0, 0, 0);
      cycle(1, 1, 10 * i, 0, 0, 0);
    end

    // Idle and disabled cycles hold outputs.
    cycle(0, 0, 0, 0, 0, 0);
    bus.en = 1'b0;
    cycle(1, 1, 77, 0, 0, 0);
    bus.en = 1'b1;

    // Delay change coincident with a sample: old delay for it, new for the next.
    cycle(0, 0, 0, 1, 0, 4);
    cycle(1, 0, 101, 1, 0, 1);
    cycle(1, 0, 102, 0, 0, 0);
    cycle(1, 0, 103, 0, 0, 0);

    // Random traffic, enables and reconfiguration.
    for (int i = 0; i < 300; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      dly = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, DEPTH - 1));
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 1)), dly);
    end
    bus.en = 1'b1;

    // Reset mid-stream, then refill to the default delay.
    rst = 1'b0;
    cycle(1, 0, 55, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < DDLY + 8; i++) begin
      cycle(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0, 0, 0);
    end

    // Full-depth delay across a pointer wrap.
    cycle(0, 0, 0, 1, 1, DEPTH - 1);
    for (int i = 0; i < DEPTH + 5; i++) begin
      cycle(1, 1, int'($urandom_range(1, 255)), 0, 0, 0);
      if (cnt[1] > DEPTH - 1 + 1 && mdelay[1] == DEPTH - 1 && i >= DEPTH - 1)
        chk("wrap_nonzero", 32'(bus.dout != '0), 32'd1);
    end

`ifdef SIGDELAY_ECHO_EN
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle(0, 0, 0, 1, 0, 1);
    cycle(1, 0, 200, 0, 0, 0);
    chk("echo_0", 32'(bus.dout), 32'd0);
    cycle(1, 0, 200, 0, 0, 0);
    chk("echo_1", 32'(bus.dout), 32'd200);
    cycle(1, 0, 200, 0, 0, 0);
    chk("echo_2", 32'(bus.dout), 32'd255);
    cycle(1, 0, 0, 0, 0, 0);
    chk("echo_3", 32'(bus.dout), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
